// File: rtl/sonata_clk_pkg.sv
// Sonata clock constants shared by the clock generator and
// by software-visible setup (UART baud, timer) in the SoC.
package sonata_clk_pkg;

  localparam real ClkInPeriodNs = 40.0;
  localparam int  ClkInFreqHz   = int'(1.0e9 / ClkInPeriodNs);

  localparam int MmcmMult   = 48;
  localparam int MmcmDivSys = 24;

  localparam longint VcoHz = longint'(ClkInFreqHz) * MmcmMult;

  localparam int SysClkFreqHz = int'(VcoHz / MmcmDivSys);
  localparam int SysClkHalfPs =
    int'(64'd500_000_000_000 / SysClkFreqHz);

  localparam int LockCyclesDef = 64;
  localparam int SyncStagesDef = 2;
  localparam int StretchDef    = 16;

endpackage

// File: rtl/rst_sync_stretch.sv
// Async-assert / sync-release reset with a post-sync stretch.
// Release lands Stages + Stretch clock edges after rst drops.
module rst_sync_stretch #(
  parameter int Stages  = 2,
  parameter int Stretch = 16
) (
  input  logic clk,
  input  logic rst,
  output logic rst_n
);

  localparam int CntW = $clog2(Stretch + 1);

  logic [Stages-1:0] sync_q;
  logic [CntW-1:0]   cnt_q;
  logic [CntW-1:0]   cnt_d;
  logic              rst_n_q;

  always_comb begin
    cnt_d = cnt_q;
    if (sync_q[Stages-1] && cnt_q != CntW'(Stretch))
      cnt_d = cnt_q + 1'b1;
  end

  // rst_n is a flop, so release cannot glitch on the compare
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      rst_n_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[Stages-2:0], 1'b1};
      cnt_q   <= cnt_d;
      rst_n_q <= sync_q[Stages-2] &&
                 (cnt_d == CntW'(Stretch));
    end
  end

  assign rst_n = rst_n_q;

endmodule

// File: rtl/sonata_clkgen.sv
// Sonata clock/reset generator: board clock in, gated system
// clock plus synchronised active-low system reset out.
module sonata_clkgen
  import sonata_clk_pkg::*;
#(
  parameter int SimSysHalfPs  = SysClkHalfPs,
  parameter int SimLockCycles = LockCyclesDef,
  parameter int RstSyncStages = SyncStagesDef,
  parameter int RstStretch    = StretchDef
) (
  input  logic IO_CLK,
  input  logic IO_RST,
  output logic IO_CLK_BUF,
  output logic clk_sys,
  output logic rst_sys_n,
  output logic pll_locked
);
  timeunit 1ns;
  timeprecision 1ps;

  localparam int      LockW = $clog2(SimLockCycles + 1);
  localparam realtime HalfT = SimSysHalfPs * 1ps;

  logic             mainclk_buf;
  logic [LockW-1:0] lock_cnt;
  logic             model_locked;
  logic             osc = 1'b0;
  logic             lock_en;
  logic             rst_async;

  assign mainclk_buf = IO_CLK;
  assign IO_CLK_BUF  = mainclk_buf;

  // lock counter saturates so it never wraps back to unlocked
  always_ff @(posedge mainclk_buf or posedge IO_RST) begin
    if (IO_RST)
      lock_cnt <= '0;
    else if (lock_cnt != LockW'(SimLockCycles))
      lock_cnt <= lock_cnt + 1'b1;
  end

  assign model_locked = (lock_cnt == LockW'(SimLockCycles));
  assign pll_locked   = model_locked;

  always begin
    #(HalfT);
    osc <= ~osc;
  end

  // enable only moves while osc is low: no runt clk_sys pulses
  always_ff @(negedge osc or posedge IO_RST) begin
    if (IO_RST)
      lock_en <= 1'b0;
    else
      lock_en <= model_locked;
  end

  assign clk_sys   = osc & lock_en;
  assign rst_async = IO_RST | ~model_locked;

  rst_sync_stretch #(
    .Stages  (RstSyncStages),
    .Stretch (RstStretch)
  ) u_rst_sync (
    .clk   (clk_sys),
    .rst   (rst_async),
    .rst_n (rst_sys_n)
  );

endmodule

// File: tb/tb_sonata_clkgen.sv
// Bench for sonata_clkgen: time-based model of lock, gating
// and reset release, plus directed power-up/loss/reset cases.
module tb_sonata_clkgen;
  timeunit 1ns;
  timeprecision 1ps;

  localparam int LockN = 64;
  localparam int RelN  = 18;

  logic io_clk, io_rst;
  logic io_clk_buf, clk_sys, rst_sys_n, pll_locked;

  int total = 0;
  int bad   = 0;

  sonata_clkgen #(
    .SimSysHalfPs  (10000),
    .SimLockCycles (LockN),
    .RstSyncStages (2),
    .RstStretch    (16)
  ) dut (
    .IO_CLK     (io_clk),
    .IO_RST     (io_rst),
    .IO_CLK_BUF (io_clk_buf),
    .clk_sys    (clk_sys),
    .rst_sys_n  (rst_sys_n),
    .pll_locked (pll_locked)
  );

  initial begin
    io_clk = 1'b0;
    #3;
    forever begin
      io_clk = 1'b1;
      #20;
      io_clk = 1'b0;
      #20;
    end
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t",
               nm, act, exp, $realtime);
    end
  endtask

  // ---------------- reference model ----------------
  int lock_edges = 0;
  int rst_pulses = 0;
  int en_pulses  = 0;
  int m_sys      = 0;
  bit force_on   = 1'b0;
  bit m_osc      = 1'b0;
  bit m_en       = 1'b0;
  logic exp_locked, exp_clk, exp_rst_n;

  always @(posedge io_clk or posedge io_rst)
    if (io_rst) lock_edges = 0;
    else lock_edges = lock_edges + 1;

  always @(posedge io_rst) rst_pulses = rst_pulses + 1;

  always_comb exp_locked = !io_rst && !force_on &&
                           lock_edges >= LockN;

  // system oscillator: high in [10+20k, 20+20k) ns
  initial forever begin
    #10;
    m_osc = ~m_osc;
    if (!m_osc) begin
      m_en      = exp_locked;
      en_pulses = rst_pulses;
    end else if (m_en && en_pulses == rst_pulses &&
                 exp_locked && m_sys < RelN) begin
      m_sys = m_sys + 1;
    end
    if (!exp_locked) m_sys = 0;
  end

  always_comb exp_clk = m_en && en_pulses == rst_pulses &&
                        !io_rst && m_osc;
  always_comb exp_rst_n = exp_locked && m_sys >= RelN;

  initial begin
    #5;
    forever begin
      chk("pll_locked", pll_locked, exp_locked);
      chk("rst_sys_n", rst_sys_n, exp_rst_n);
      chk("clk_sys", clk_sys, exp_clk);
      chk("io_clk_buf", io_clk_buf, io_clk);
      #10;
    end
  end

  // ---------------- monitors ----------------
  int      sys_pos    = 0;
  realtime t_sys_pos  = -1.0;
  realtime t_sys_prev = -1.0;
  realtime t_sys_neg  = -1.0;
  realtime t_sys_edge = 0.0;
  realtime tb_pos = 0.0, tb_prev = 0.0, tb_neg = 0.0;

  always @(posedge clk_sys) begin
    t_sys_prev = t_sys_pos;
    t_sys_pos  = $realtime;
    sys_pos    = sys_pos + 1;
  end

  always @(negedge clk_sys) t_sys_neg = $realtime;

  always @(clk_sys) begin
    if ($realtime > 1.0 && !(clk_sys == 1'b0 && io_rst))
      chk("clk_sys_min_width",
          logic'(($realtime - t_sys_edge) >= 9.999), 1'b1);
    t_sys_edge = $realtime;
  end

  always @(posedge rst_sys_n)
    chk("rst_rise_at_clk_posedge",
        logic'(t_sys_pos == $realtime), 1'b1);

  always @(posedge io_clk_buf) begin
    tb_prev = tb_pos;
    tb_pos  = $realtime;
  end

  always @(negedge io_clk_buf) tb_neg = $realtime;

  // ---------------- helpers ----------------
  task automatic wait_sys(input int n, input string nm);
    int      target;
    realtime dl;
    target = sys_pos + n;
    dl     = $realtime + n * 20.0 + 60.0;
    while (sys_pos < target && $realtime < dl) #0.25;
    chk({nm, "_timeout"}, logic'(sys_pos >= target), 1'b1);
  endtask

  task automatic align();
    realtime r, d;
    r = $realtime - 10.0 * $floor($realtime / 10.0);
    d = 7.0 - r;
    if (d <= 0.0) d = d + 10.0;
    #(d);
  endtask

  task automatic check_release(input string nm);
    repeat (LockN - 1) @(posedge io_clk);
    #1;
    chk({nm, "_lock63"}, pll_locked, 1'b0);
    @(posedge io_clk);
    #1;
    chk({nm, "_lock64"}, pll_locked, 1'b1);
    wait_sys(RelN - 1, {nm, "_e17"});
    #1;
    chk({nm, "_rst_e17"}, rst_sys_n, 1'b0);
    wait_sys(1, {nm, "_e18"});
    #1;
    chk({nm, "_rst_e18"}, rst_sys_n, 1'b1);
  endtask

  task automatic rst_pulse(input realtime w, input string nm);
    io_rst = 1'b1;
    #0.01;
    chk({nm, "_lock_now"}, pll_locked, 1'b0);
    chk({nm, "_rst_now"}, rst_sys_n, 1'b0);
    chk({nm, "_clk_now"}, clk_sys, 1'b0);
    #(w - 0.01);
    io_rst = 1'b0;
  endtask

  task automatic lose_lock(input string nm);
    force_on = 1'b1;
    force dut.model_locked = 1'b0;
    #0.01;
    chk({nm, "_lock_now"}, pll_locked, 1'b0);
    chk({nm, "_rst_now"}, rst_sys_n, 1'b0);
    #99.99;
    release dut.model_locked;
    force_on = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  realtime widths [6] = '{1.0, 2.0, 3.0, 5.0, 12.0, 31.0};

  initial begin
    io_rst = 1'b1;
    #1;
    chk("reset_lock", pll_locked, 1'b0);
    chk("reset_rst", rst_sys_n, 1'b0);
    chk("reset_clk", clk_sys, 1'b0);

    repeat (10) @(posedge io_clk);
    #4;
    io_rst = 1'b0;
    check_release("pwrup");

    wait_sys(2, "meas");
    #12;
    chk("sys_period_ps", int'((t_sys_pos - t_sys_prev) * 1000.0),
        20000);
    chk("sys_high_ps", int'((t_sys_neg - t_sys_pos) * 1000.0),
        10000);
    #100;
    chk("buf_period_ps", int'((tb_pos - tb_prev) * 1000.0), 40000);
    chk("buf_high_ps",
        int'(((tb_neg > tb_pos) ? tb_neg - tb_pos
                                : tb_neg - tb_prev) * 1000.0),
        20000);

    align();
    rst_pulse(5.0, "pulse5");
    check_release("pulse5");

    #200;
    align();
    lose_lock("loss");
    #0.01;
    chk("loss_relock", pll_locked, 1'b1);
    wait_sys(RelN - 1, "loss_e17");
    #1;
    chk("loss_rst_e17", rst_sys_n, 1'b0);
    wait_sys(1, "loss_e18");
    #1;
    chk("loss_rst_e18", rst_sys_n, 1'b1);

    align();
    rst_pulse(5.0, "pre10");
    repeat (LockN) @(posedge io_clk);
    wait_sys(12, "cnt10");
    align();
    rst_pulse(5.0, "at10");
    #1;
    chk("at10_held", rst_sys_n, 1'b0);
    check_release("at10");

    for (int it = 0; it < 10; it++) begin
      int sel;
      sel = $urandom_range(0, 2);
      align();
      if (sel == 0)
        rst_pulse(widths[$urandom_range(0, 5)], "rnd_rst");
      else if (sel == 1)
        lose_lock("rnd_loss");
      #($urandom_range(20, 350) * 10.0);
    end

    #3500;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
